seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
Parametrised, runtime-programmable serial bit-pattern detector. It is the successor to the fixed 4-bit Mealy sequence FSM.
- Pattern and length are loaded at runtime.
- Overlapping or non-overlapping detection is selectable per load.
- The match output is Mealy (same-cycle).
- A saturating match counter is included.
- Sits on a 1-bit serial data path, e.g. behind a deserializer or line-code front end.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
COUNT_W, 8, width of saturating match counter
LEN_W, $clog2(MAX_LEN+1), width of length fields (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_load  input  1  load pattern/length/mode this cycle
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is first received, bit [0] is last
cfg_len  input  LEN_W  pattern length, legal range 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
enable  input  1  0 forces DISABLED state
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  serial data bit
match  output  1  Mealy: high in the same cycle as the in_bit that completes the pattern
match_count  output  COUNT_W  number of matches since reset or clear, saturating
count_sat  output  1  match_count is at its maximum value
cfg_err  output  1  last cfg_load carried an illegal length (sticky until a legal load)
count_clr  input  1  synchronous clear of match_count and count_sat
state_o  output  2  current FSM state, for debug

Behaviour:
- Reset (asynchronous) sets:
  - state = DISABLED, history = 0, fill = 0
  - pattern = 0, len = 1, overlap = 0
  - match_count = 0, count_sat = 0, cfg_err = 0
  - match = 0 (combinationally)
- States:
  - DISABLED (00): nothing accepted; match = 0.
  - FILL (01): fewer than len-1 bits in history.
  - HUNT (10): at least len-1 bits in history, so a match is possible.
  - Encoding 11 is unused; an illegal state recovers to DISABLED on the next clock.
- Transitions:
  - DISABLED to FILL when enable = 1 and cfg_load = 0.
  - Any state to DISABLED when enable = 0, which also clears history and fill.
- Accept: an accepted bit is one with in_valid & enable & state != DISABLED & !cfg_load. On an accepted bit:
  - history <= {history[MAX_LEN-2:0], in_bit}
  - fill <= min(fill+1, MAX_LEN)
- Match (combinational):
  - match = accepted & (fill >= len-1) & ({history[len-2:0], in_bit} == pattern[len-1:0]).
  - For len = 1: match = accepted & (in_bit == pattern[0]).
- On a match:
  - Overlap mode: history and fill keep shifting normally.
  - Non-overlap mode: fill <= 0 and state <= FILL, so the next match needs len fresh bits.
- FILL to HUNT when the registered fill reaches len-1.
- in_valid = 0: all state, history and fill hold; match = 0.
- cfg_load (highest priority after reset):
  - Legal len: loads pattern, len and overlap; clears history and fill; state <= FILL if enable, else DISABLED; cfg_err <= 0.
  - Illegal len (0 or > MAX_LEN): ignored, cfg_err <= 1.
  - match = 0 in the load cycle; the bit presented in that cycle is dropped.
  - match_count is not affected.
- Counter:
  - match_count increments on each match and holds at 2^COUNT_W-1.
  - count_sat = (match_count == max).
  - count_clr zeroes both. A match in the same cycle as count_clr sets match_count = 1.
- Latency: match has 0 cycles from in_bit; match_count updates 1 cycle after the match.
- Only the low len bits of cfg_pattern are compared; the upper bits are don't-care.

Decomposition:
- Package seq_det_pkg holds:
  - state typedef {DISABLED, FILL, HUNT}
  - state encoding constants
  - LEN_W derivation function
- One sub-module: sat_counter (COUNT_W, inc, clr, count, sat), reusable elsewhere in the block library.
- Window compare stays inline in seq_detector_prog.

Test Plan:
1. Load pattern 4'b1011, len 4, overlap = 0; stream 1,0,1,1,0,1,1 -> match only on bit 4; match_count = 1.
2. Same pattern with overlap = 1; same stream -> match on bits 4 and 7; match_count = 2.
3. in_valid low for 3 cycles between bits 2 and 3 of 1011 -> state held; match still on the 4th valid bit; match = 0 during the gap cycles.
4. COUNT_W = 4, pattern 1'b1, len 1; 20 ones -> match_count = 15, count_sat = 1. Then count_clr together with a match -> match_count = 1.
5. cfg_load with len = 0 -> cfg_err = 1; previous pattern still detected. A legal load afterwards -> cfg_err = 0 and history cleared.
6. Assert reset mid-pattern, after 101 -> state = DISABLED and match_count = 0 immediately. After release and enable, 1 then 1 gives no match until a full new 1011 (once pattern 1011 is reloaded; reset restores pattern = 0, len = 1).

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state encoding and width helpers for the programmable sequence detector
package seq_det_pkg;
  localparam logic [1:0] ST_DISABLED = 2'b00;
  localparam logic [1:0] ST_FILL = 2'b01;
  localparam logic [1:0] ST_HUNT = 2'b10;
  typedef enum logic [1:0] {
    DISABLED = ST_DISABLED,
    FILL     = ST_FILL,
    HUNT     = ST_HUNT
  } state_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clear wins over increment but keeps a coincident event
module sat_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               sat
);
  assign sat = &count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= COUNT_W'(inc);
    else if (inc && !sat) count <= count + COUNT_W'(1);
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector with Mealy match and saturating count
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int COUNT_W = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               enable,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [COUNT_W-1:0] match_count,
  output logic               count_sat,
  output logic               cfg_err,
  input  logic               count_clr,
  output logic [1:0]         state_o
);
  state_t state, state_n;
  logic [MAX_LEN-2:0] history, history_n;
  logic [MAX_LEN-1:0] pattern, window, mask;
  logic [LEN_W-1:0] fill, fill_n, fill_inc, len, len_m1;
  logic overlap, accepted, len_ok, hit, restart;

  assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign accepted = in_valid & enable & (state != DISABLED) & ~cfg_load;
  assign window   = {history, in_bit};
  // Only the low len bits take part in the compare
  assign mask     = ~({MAX_LEN{1'b1}} << len);
  assign len_m1   = len - LEN_W'(1);
  assign fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
  assign hit      = (fill >= len_m1) && (((window ^ pattern) & mask) == '0);
  assign restart  = match & ~overlap;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= DISABLED;
      history <= '0;
      fill    <= '0;
    end else begin
      state   <= state_n;
      history <= history_n;
      fill    <= fill_n;
    end

  always_comb begin
    state_n   = state;
    history_n = history;
    fill_n    = fill;
    if (cfg_load) begin
      if (len_ok || !enable) begin
        state_n   = enable ? FILL : DISABLED;
        history_n = '0;
        fill_n    = '0;
      end
    end else if (!enable) begin
      state_n   = DISABLED;
      history_n = '0;
      fill_n    = '0;
    end else begin
      case (state)
        DISABLED: state_n = FILL;
        FILL, HUNT: begin
          history_n = accepted ? window[MAX_LEN-2:0] : history;
          fill_n    = !accepted ? fill : restart ? '0 : fill_inc;
          state_n   = restart ? FILL : (fill_n >= len_m1) ? HUNT : FILL;
        end
        default: state_n = DISABLED;
      endcase
    end
  end

  always_comb begin
    match   = accepted & hit;
    state_o = state;
  end

  // An illegal length leaves the previous configuration in force
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pattern <= '0;
      len     <= LEN_W'(1);
      overlap <= 1'b0;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      cfg_err <= !len_ok;
      if (len_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
      end
    end

  sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (count_clr),
    .count(match_count),
    .sat  (count_sat)
  );
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed and random checks of seq_detector_prog against a queue-based model
module tb_seq_detector_prog;
  localparam int ML = 8;
  localparam int CW = 4;
  localparam int LW = $clog2(ML + 1);
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 0, reset = 1;
  logic cfg_load = 0, cfg_overlap = 0, enable = 0, in_valid = 0, in_bit = 0, count_clr = 0;
  logic [ML-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic match, count_sat, cfg_err;
  logic [CW-1:0] match_count;
  logic [1:0] state_o;

  int vec = 0, miss = 0;

  bit m_active, m_ov, m_err, m_exp;
  bit m_q[$];
  logic [ML-1:0] m_pat;
  int m_len, m_cnt;

  seq_detector_prog #(.MAX_LEN(ML), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .enable(enable), .in_valid(in_valid),
    .in_bit(in_bit), .match(match), .match_count(match_count), .count_sat(count_sat),
    .cfg_err(cfg_err), .count_clr(count_clr), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // The last len received bits, oldest first, must equal pattern[len-1] down to pattern[0]
  function automatic bit model_match();
    int n;
    bit b;
    if (!(in_valid && enable && m_active && !cfg_load)) return 0;
    n = m_q.size();
    if (n < m_len - 1) return 0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == m_len - 1) ? in_bit : m_q[n - (m_len - 1) + k];
      if (b != m_pat[m_len - 1 - k]) return 0;
    end
    return 1;
  endfunction

  function automatic void model_reset();
    m_active = 0; m_q.delete(); m_pat = '0; m_len = 1; m_ov = 0; m_err = 0; m_cnt = 0;
  endfunction

  task automatic apply(input bit ld, input logic [ML-1:0] pat, input int ln, input bit ov,
                       input bit en, input bit v, input bit b, input bit clr);
    cfg_load = ld; cfg_pattern = pat; cfg_len = LW'(ln); cfg_overlap = ov;
    enable = en; in_valid = v; in_bit = b; count_clr = clr;
    m_exp = model_match();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    if (count_clr) m_cnt = m_exp;
    else if (m_exp && m_cnt < MAXC) m_cnt++;
    if (cfg_load) begin
      if (cfg_len >= 1 && cfg_len <= ML) begin
        m_pat = cfg_pattern; m_len = cfg_len; m_ov = cfg_overlap; m_err = 0;
        m_q.delete(); m_active = enable;
      end else begin
        m_err = 1;
        if (!enable) begin m_active = 0; m_q.delete(); end
      end
    end else if (!enable) begin
      m_active = 0; m_q.delete();
    end else if (!m_active) m_active = 1;
    else if (in_valid) begin
      if (m_exp && !m_ov) m_q.delete();
      else begin
        m_q.push_back(in_bit);
        if (m_q.size() > ML) void'(m_q.pop_front());
      end
    end
    #1;
  endtask

  task automatic do_reset();
    cfg_load = 0; enable = 0; in_valid = 0; count_clr = 0;
    reset = 1;
    #1;
    model_reset();
    vec++; if (state_o !== 2'b00) begin miss++; $display("FAIL reset state_o: got %b want 00", state_o); end
    vec++; if (match_count !== '0) begin miss++; $display("FAIL reset match_count: got %0d want 0", match_count); end
    vec++; if (count_sat !== 1'b0 || cfg_err !== 1'b0 || match !== 1'b0) begin
      miss++; $display("FAIL reset flags: sat=%b err=%b match=%b want 000", count_sat, cfg_err, match);
    end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic run_1011(input bit ov, input logic [ML-1:0] pat, input logic [6:0] want);
    logic [6:0] seq = 7'b1011011;
    logic [6:0] got;
    apply(1, pat, 4, ov, 1, 0, 0, 1); tick();
    for (int i = 6; i >= 0; i--) begin
      apply(0, '0, 0, 0, 1, 1, seq[i], 0);
      got[i] = match;
      vec++; if (match !== m_exp) begin miss++; $display("FAIL ov%0d bit %0d: match=%b want %b", ov, 7 - i, match, m_exp); end
      tick();
    end
    vec++; if (got !== want) begin miss++; $display("FAIL ov%0d match trace: got %b want %b", ov, got, want); end
    vec++; if (match_count !== CW'($countones(want))) begin
      miss++; $display("FAIL ov%0d count: got %0d want %0d", ov, match_count, $countones(want));
    end
  endtask

  task automatic test_nonoverlap();
    run_1011(0, 8'b0000_1011, 7'b0001000);
  endtask

  task automatic test_overlap();
    run_1011(1, 8'hAB, 7'b0001001);
  endtask

  task automatic test_gap();
    logic [1:0] st;
    apply(1, 8'b1011, 4, 0, 1, 0, 0, 1); tick();
    apply(0, '0, 0, 0, 1, 1, 1, 0); tick();
    apply(0, '0, 0, 0, 1, 1, 0, 0); tick();
    st = state_o;
    for (int i = 0; i < 3; i++) begin
      apply(0, '0, 0, 0, 1, 0, 1, 0);
      vec++; if (match !== 1'b0) begin miss++; $display("FAIL gap %0d match: got %b want 0", i, match); end
      tick();
      vec++; if (state_o !== st) begin miss++; $display("FAIL gap %0d state: got %b want %b", i, state_o, st); end
    end
    apply(0, '0, 0, 0, 1, 1, 1, 0);
    vec++; if (match !== 1'b0) begin miss++; $display("FAIL gap bit3 match: got %b want 0", match); end
    tick();
    apply(0, '0, 0, 0, 1, 1, 1, 0);
    vec++; if (match !== 1'b1) begin miss++; $display("FAIL gap bit4 match: got %b want 1", match); end
    tick();
  endtask

  task automatic test_saturate();
    apply(1, 8'b1, 1, 1, 1, 0, 0, 1); tick();
    for (int i = 0; i < 20; i++) begin
      apply(0, '0, 0, 0, 1, 1, 1, 0);
      vec++; if (match !== m_exp) begin miss++; $display("FAIL sat bit %0d: match=%b want %b", i, match, m_exp); end
      tick();
    end
    vec++; if (match_count !== CW'(MAXC) || count_sat !== 1'b1) begin
      miss++; $display("FAIL saturate: count=%0d sat=%b want %0d/1", match_count, count_sat, MAXC);
    end
    apply(0, '0, 0, 0, 1, 1, 1, 1); tick();
    vec++; if (match_count !== CW'(1) || count_sat !== 1'b0) begin
      miss++; $display("FAIL clr+match: count=%0d sat=%b want 1/0", match_count, count_sat);
    end
  endtask

  task automatic test_cfg_err();
    apply(1, 8'hFF, 0, 0, 1, 1, 1, 0);
    vec++; if (match !== 1'b0) begin miss++; $display("FAIL load-cycle match: got %b want 0", match); end
    tick();
    vec++; if (cfg_err !== 1'b1) begin miss++; $display("FAIL len0 cfg_err: got %b want 1", cfg_err); end
    apply(0, '0, 0, 0, 1, 1, 1, 0);
    vec++; if (match !== 1'b1) begin miss++; $display("FAIL old pattern kept: match=%b want 1", match); end
    tick();
    apply(1, 8'h00, 9, 0, 1, 0, 0, 0); tick();
    vec++; if (cfg_err !== 1'b1) begin miss++; $display("FAIL len9 cfg_err: got %b want 1", cfg_err); end
    apply(0, '0, 0, 0, 1, 1, 0, 0); tick();
    apply(0, '0, 0, 0, 1, 1, 1, 0); tick();
    apply(1, 8'b1011, 4, 1, 1, 0, 0, 0); tick();
    vec++; if (cfg_err !== 1'b0) begin miss++; $display("FAIL legal load cfg_err: got %b want 0", cfg_err); end
    apply(0, '0, 0, 0, 1, 1, 1, 0);
    vec++; if (match !== 1'b0) begin miss++; $display("FAIL history cleared: match=%b want 0", match); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] p = 4'b1011;
    apply(1, 8'b1011, 4, 0, 1, 0, 0, 0); tick();
    for (int i = 3; i >= 1; i--) begin apply(0, '0, 0, 0, 1, 1, p[i], 0); tick(); end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, '0, 0, 0, 1, 1, 1, 0);
      vec++; if (match !== 1'b0) begin miss++; $display("FAIL post-reset ones %0d: match=%b want 0", i, match); end
      tick();
    end
    apply(1, 8'b1011, 4, 0, 1, 0, 0, 0); tick();
    for (int i = 3; i >= 0; i--) begin
      apply(0, '0, 0, 0, 1, 1, p[i], 0);
      vec++; if (match !== (i == 0)) begin miss++; $display("FAIL post-reset 1011 bit %0d: match=%b want %b", 3 - i, match, i == 0); end
      tick();
    end
  endtask

  task automatic test_random();
    bit ld;
    for (int c = 0; c < 3000; c++) begin
      ld = ($urandom % 16) == 0;
      apply(ld, ML'($urandom), $urandom_range(0, 9), 1'($urandom), ($urandom % 40) != 0,
            ($urandom % 4) != 0, 1'($urandom), ($urandom % 80) == 0);
      vec++; if (match !== m_exp) begin miss++; $display("FAIL rnd %0d match: got %b want %b", c, match, m_exp); end
      tick();
      vec++; if (match_count !== CW'(m_cnt) || count_sat !== (m_cnt == MAXC)) begin
        miss++; $display("FAIL rnd %0d count: got %0d/%b want %0d", c, match_count, count_sat, m_cnt);
      end
      vec++; if (cfg_err !== m_err || (state_o == 2'b00) !== !m_active || state_o === 2'b11) begin
        miss++; $display("FAIL rnd %0d status: err=%b state=%b want err=%b active=%b", c, cfg_err, state_o, m_err, m_active);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonoverlap();
    test_overlap();
    test_gap();
    test_saturate();
    test_cfg_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
